add4_seq_arbiter: RTL

//  Sequencer/arbiter that shares one combinational 4-bit adder (add4 datapath) among NREQ requesters.

---
 rtl/add4_seq_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/add4_seq_arbiter.sv
// Round-robin sequencer that time-shares one external 4-bit adder among NREQ requesters.
// Each accepted request is summed one nibble per cycle, LSB first, with the carry held in a register.
module add4_seq_arbiter #(
  parameter  int NIBBLES = 4,
  parameter  int NREQ    = 2,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_ci,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_ci,
  input  logic [3:0]        add_sum,
  input  logic              add_co,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_co
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    a_reg, b_reg;
  logic            carry_reg;
  logic [KW-1:0]   k_reg;
  logic [IW-1:0]   last_grant_reg;

  logic [W-1:0]    op_a [NREQ];
  logic [W-1:0]    op_b [NREQ];
  logic [3:0]      a_nib [NIBBLES];
  logic [3:0]      b_nib [NIBBLES];

  logic            grant_found;
  logic [IW-1:0]   grant_idx;
  logic            accept;
  logic            last_nibble;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign op_a[gi] = req_a[gi*W +: W];
      assign op_b[gi] = req_b[gi*W +: W];
    end
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[gi*4 +: 4];
      assign b_nib[gi] = b_reg[gi*4 +: 4];
    end
  endgenerate

  // Scan distances 0..NREQ-1 from the requester just after the last grant.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!grant_found && req_valid[j] &&
            (j == (int'(last_grant_reg) + 1 + i) % NREQ)) begin
          grant_found = 1'b1;
          grant_idx   = IW'(j);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = (state_reg == IDLE) && grant_found && (grant_idx == IW'(j));
    end
  end

  assign accept      = |(req_valid & req_ready);
  assign last_nibble = (k_reg == KW'(NIBBLES - 1));
  assign rsp_valid   = (state_reg == DONE);

  always_comb begin
    add_a  = 4'd0;
    add_b  = 4'd0;
    add_ci = 1'b0;
    if (state_reg == RUN) begin
      add_a  = a_nib[k_reg];
      add_b  = b_nib[k_reg];
      add_ci = carry_reg;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)      state_next = RUN;
      RUN:     if (last_nibble) state_next = DONE;
      DONE:    if (rsp_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Pointer resets to NREQ-1 so requester 0 is first in line after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg          <= '0;
      b_reg          <= '0;
      carry_reg      <= 1'b0;
      k_reg          <= '0;
      last_grant_reg <= IW'(NREQ - 1);
      rsp_id         <= '0;
      rsp_sum        <= '0;
      rsp_co         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg          <= op_a[grant_idx];
            b_reg          <= op_b[grant_idx];
            carry_reg      <= req_ci[grant_idx];
            rsp_id         <= grant_idx;
            last_grant_reg <= grant_idx;
            k_reg          <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (k_reg == KW'(i)) rsp_sum[i*4 +: 4] <= add_sum;
          end
          carry_reg <= add_co;
          if (last_nibble) begin
            rsp_co <= add_co;
            k_reg  <= '0;
          end else begin
            k_reg  <= k_reg + KW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
